// File: rtl/mem_arbiter_nport.sv
// ---------------------------------------------------------------------------
// mem_arbiter_nport
//
// Shares the single block-wide memory controller between NUM_PORTS cache
// clients (icache, dcache, prefetch, page-walk, ...). At most one
// transaction is in flight. The winner is chosen by round-robin
// (RR_MODE=1) or fixed priority with port 0 highest (RR_MODE=0).
//
// Per transaction the arbiter walks IDLE -> BUSY -> DONE -> IDLE:
//   IDLE : pick a winner among (req & ~mask) and latch its operands
//   BUSY : hold mem_* stable until mem_data_valid
//   DONE : one-cycle done pulse to the owner, then back to IDLE
// The port that just completed is masked for the following IDLE cycle.
// This lets another waiting port in even under fixed priority.
//
// Ports
//   clk, rst        clock, synchronous active-high reset
//   req, wr_en      per-port request level and write(1)/read(0)
//   addr, data_in   flattened per-port address / write line
//   data_out        last line returned by memory (shared by all ports)
//   done            one-hot, one-cycle completion pulse
//   grant_id        index of the port owning memory
//   busy            transaction in flight (BUSY or DONE)
//   mem_address, mem_data_out, mem_req, mem_wr_en
//                   request side of the memory controller
//   data_from_mem, mem_data_valid
//                   response side of the memory controller
// ---------------------------------------------------------------------------
module mem_arbiter_nport #(
  parameter int NUM_PORTS   = 2,
  parameter int ADDR_WIDTH  = 64,
  parameter int BLOCK_WIDTH = 512,
  parameter int RR_MODE     = 1,
  parameter int IDW         = $clog2(NUM_PORTS)
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_PORTS-1:0]             req,
  input  logic [NUM_PORTS-1:0]             wr_en,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0]  addr,
  input  logic [NUM_PORTS*BLOCK_WIDTH-1:0] data_in,
  output logic [BLOCK_WIDTH-1:0]           data_out,
  output logic [NUM_PORTS-1:0]             done,
  output logic [IDW-1:0]                   grant_id,
  output logic                             busy,
  output logic [ADDR_WIDTH-1:0]            mem_address,
  output logic [BLOCK_WIDTH-1:0]           mem_data_out,
  output logic                             mem_req,
  output logic                             mem_wr_en,
  input  logic [BLOCK_WIDTH-1:0]           data_from_mem,
  input  logic                             mem_data_valid
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e                 state_q, state_d;
  logic                   mem_req_q, mem_req_d;
  logic                   mem_wr_en_q, mem_wr_en_d;
  logic [ADDR_WIDTH-1:0]  mem_address_q, mem_address_d;
  logic [BLOCK_WIDTH-1:0] mem_data_out_q, mem_data_out_d;
  logic [BLOCK_WIDTH-1:0] data_out_q, data_out_d;
  logic [NUM_PORTS-1:0]   done_q, done_d;
  logic [IDW-1:0]         grant_id_q, grant_id_d;
  logic                   busy_q, busy_d;
  logic [IDW-1:0]         last_grant_q, last_grant_d;
  logic [NUM_PORTS-1:0]   mask_q, mask_d;

  // Per-port views of the flattened operand buses.
  logic [ADDR_WIDTH-1:0]  addr_arr [NUM_PORTS];
  logic [BLOCK_WIDTH-1:0] data_arr [NUM_PORTS];

  // Arbitration. Round-robin is split into two lowest-index searches: first
  // among eligible ports above last_grant, then wrap to all eligible ports.
  // The unrestricted search alone is the fixed-priority result.
  logic [NUM_PORTS-1:0] eligible;
  logic [NUM_PORTS-1:0] above_last;
  logic [NUM_PORTS-1:0] elig_hi;
  logic [NUM_PORTS:0]   all_seen;
  logic [NUM_PORTS:0]   hi_seen;
  logic [IDW-1:0]       all_enc [NUM_PORTS+1];
  logic [IDW-1:0]       hi_enc  [NUM_PORTS+1];
  logic                 any_eligible;
  logic                 any_hi;
  logic [IDW-1:0]       rr_winner;
  logic [IDW-1:0]       fp_winner;
  logic [IDW-1:0]       winner;
  logic [NUM_PORTS-1:0] grant_onehot;

  assign eligible = req & ~mask_q;
  assign elig_hi  = eligible & above_last;

  assign all_seen[0] = 1'b0;
  assign hi_seen[0]  = 1'b0;
  assign all_enc[0]  = '0;
  assign hi_enc[0]   = '0;

  for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_port
    assign addr_arr[gi]   = addr[gi*ADDR_WIDTH +: ADDR_WIDTH];
    assign data_arr[gi]   = data_in[gi*BLOCK_WIDTH +: BLOCK_WIDTH];
    assign above_last[gi] = (IDW'(gi) > last_grant_q);

    // Priority chains: a port contributes its index only when no
    // lower-index port in the same vector is already set.
    assign all_seen[gi+1] = all_seen[gi] | eligible[gi];
    assign hi_seen[gi+1]  = hi_seen[gi] | elig_hi[gi];
    assign all_enc[gi+1]  = all_enc[gi] |
                            ((eligible[gi] && !all_seen[gi]) ? IDW'(gi) : '0);
    assign hi_enc[gi+1]   = hi_enc[gi] |
                            ((elig_hi[gi] && !hi_seen[gi]) ? IDW'(gi) : '0);
  end

  assign any_eligible = all_seen[NUM_PORTS];
  assign any_hi       = hi_seen[NUM_PORTS];
  assign fp_winner    = all_enc[NUM_PORTS];
  assign rr_winner    = any_hi ? hi_enc[NUM_PORTS] : all_enc[NUM_PORTS];
  assign winner       = (RR_MODE != 0) ? rr_winner : fp_winner;

  assign grant_onehot = NUM_PORTS'(1) << grant_id_q;

  // Next-state and output logic.
  always_comb begin
    state_d        = state_q;
    mem_req_d      = mem_req_q;
    mem_wr_en_d    = mem_wr_en_q;
    mem_address_d  = mem_address_q;
    mem_data_out_d = mem_data_out_q;
    data_out_d     = data_out_q;
    done_d         = done_q;
    grant_id_d     = grant_id_q;
    busy_d         = busy_q;
    last_grant_d   = last_grant_q;
    mask_d         = mask_q;

    case (state_q)
      ST_IDLE: begin
        // The mask only lives for a single IDLE evaluation.
        mask_d = '0;
        if (any_eligible) begin
          state_d        = ST_BUSY;
          mem_req_d      = 1'b1;
          busy_d         = 1'b1;
          grant_id_d     = winner;
          last_grant_d   = winner;
          mem_address_d  = addr_arr[winner];
          mem_data_out_d = data_arr[winner];
          mem_wr_en_d    = wr_en[winner];
        end
      end

      ST_BUSY: begin
        // Writes also finish on mem_data_valid; data_out is refreshed
        // regardless and write clients simply ignore it.
        if (mem_data_valid) begin
          state_d    = ST_DONE;
          data_out_d = data_from_mem;
          done_d     = grant_onehot;
          mem_req_d  = 1'b0;
          mask_d     = grant_onehot;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
        done_d  = '0;
        busy_d  = 1'b0;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      mem_req_q      <= 1'b0;
      mem_wr_en_q    <= 1'b0;
      mem_address_q  <= '0;
      mem_data_out_q <= '0;
      data_out_q     <= '0;
      done_q         <= '0;
      grant_id_q     <= '0;
      busy_q         <= 1'b0;
      // Starting one below port 0 makes port 0 the first round-robin winner.
      last_grant_q   <= IDW'(NUM_PORTS - 1);
      mask_q         <= '0;
    end else begin
      state_q        <= state_d;
      mem_req_q      <= mem_req_d;
      mem_wr_en_q    <= mem_wr_en_d;
      mem_address_q  <= mem_address_d;
      mem_data_out_q <= mem_data_out_d;
      data_out_q     <= data_out_d;
      done_q         <= done_d;
      grant_id_q     <= grant_id_d;
      busy_q         <= busy_d;
      last_grant_q   <= last_grant_d;
      mask_q         <= mask_d;
    end
  end

  assign data_out     = data_out_q;
  assign done         = done_q;
  assign grant_id     = grant_id_q;
  assign busy         = busy_q;
  assign mem_address  = mem_address_q;
  assign mem_data_out = mem_data_out_q;
  assign mem_req      = mem_req_q;
  assign mem_wr_en    = mem_wr_en_q;

endmodule

// File: tb/tb_mem_arbiter_nport.sv
// ---------------------------------------------------------------------------
// tb_mem_arbiter_nport
//
// Two 4-port arbiters side by side: instance 0 round-robin, instance 1
// fixed priority. A transaction-level model tracks each arbiter as
// "idle / owned by port w awaiting memory / completion cycle". It derives
// every output from that state and the latched transaction record. A
// negedge process compares all DUT outputs with the model on every cycle.
// Directed scenarios add literal expectations, including grant orders.
// A randomized traffic phase with a randomized memory responder follows.
// ---------------------------------------------------------------------------
module tb_mem_arbiter_nport;

  localparam int N  = 4;
  localparam int AW = 32;
  localparam int BW = 64;
  localparam int NI = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [N-1:0]    req_s   [NI];
  logic [N-1:0]    wr_s    [NI];
  logic [N*AW-1:0] addr_s  [NI];
  logic [N*BW-1:0] din_s   [NI];
  logic [BW-1:0]   fmem_s  [NI];
  logic            mvalid_s[NI];
  logic [BW-1:0]   dout_o  [NI];
  logic [BW-1:0]   mdo_o   [NI];
  logic [N-1:0]    done_o  [NI];
  logic [1:0]      gid_o   [NI];
  logic            busy_o  [NI];
  logic            mreq_o  [NI];
  logic            mwr_o   [NI];
  logic [AW-1:0]   maddr_o [NI];

  for (genvar gi = 0; gi < NI; gi++) begin : g_dut
    mem_arbiter_nport #(
      .NUM_PORTS  (N),
      .ADDR_WIDTH (AW),
      .BLOCK_WIDTH(BW),
      .RR_MODE    (gi == 0 ? 1 : 0)
    ) u_dut (
      .clk           (clk),
      .rst           (rst),
      .req           (req_s[gi]),
      .wr_en         (wr_s[gi]),
      .addr          (addr_s[gi]),
      .data_in       (din_s[gi]),
      .data_out      (dout_o[gi]),
      .done          (done_o[gi]),
      .grant_id      (gid_o[gi]),
      .busy          (busy_o[gi]),
      .mem_address   (maddr_o[gi]),
      .mem_data_out  (mdo_o[gi]),
      .mem_req       (mreq_o[gi]),
      .mem_wr_en     (mwr_o[gi]),
      .data_from_mem (fmem_s[gi]),
      .mem_data_valid(mvalid_s[gi])
    );
  end

  int n_checks = 0;
  int n_errors = 0;
  bit cmp_en   = 1'b0;

  task automatic chk(input string nm, input int k, input logic [63:0] act,
                     input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s[inst%0d] t=%0t: got %h, want %h", nm, k, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // ph: 0 = no owner, 1 = owner waiting for memory, 2 = completion cycle
  int            ph    [NI];
  int            gw    [NI];
  int            lastg [NI];
  logic [N-1:0]  blk   [NI];
  logic [AW-1:0] t_addr[NI];
  logic [BW-1:0] t_data[NI];
  logic          t_wr  [NI];
  logic [BW-1:0] m_dout[NI];
  int            ghist [NI][64];
  int            gcnt  [NI] = '{0, 0};
  int            w_m;

  // First eligible port, scanning from last+1 (round-robin) or from 0.
  function automatic int pick(input logic [N-1:0] elig, input int last, input bit rr);
    int r;
    logic [N-1:0] sh;
    r = -1;
    for (int s = N; s >= 1; s--) begin
      int p;
      p  = rr ? (last + s) % N : s - 1;
      sh = elig >> p;
      if (sh[0]) r = p;
    end
    return r;
  endfunction

  always @(posedge clk) begin
    for (int k = 0; k < NI; k++) begin
      if (rst) begin
        ph[k] = 0; gw[k] = 0; lastg[k] = N - 1; blk[k] = '0;
        t_addr[k] = '0; t_data[k] = '0; t_wr[k] = 1'b0; m_dout[k] = '0;
      end else if (ph[k] == 0) begin
        w_m    = pick(req_s[k] & ~blk[k], lastg[k], k == 0);
        blk[k] = '0;
        if (w_m >= 0) begin
          gw[k] = w_m; lastg[k] = w_m; ph[k] = 1;
          t_addr[k] = AW'(addr_s[k] >> (w_m * AW));
          t_data[k] = BW'(din_s[k] >> (w_m * BW));
          t_wr[k]   = 1'(wr_s[k] >> w_m);
          if (gcnt[k] < 64) begin
            ghist[k][gcnt[k]] = w_m;
            gcnt[k]++;
          end
        end
      end else if (ph[k] == 1) begin
        if (mvalid_s[k]) begin
          m_dout[k] = fmem_s[k];
          blk[k]    = N'(1) << gw[k];
          ph[k]     = 2;
        end
      end else begin
        ph[k] = 0;
      end
    end
  end

  // ---------------- per-cycle comparison ----------------
  always @(negedge clk) begin
    if (cmp_en) begin
      for (int k = 0; k < NI; k++) begin
        chk("mem_req",      k, 64'(mreq_o[k]),  64'(ph[k] == 1));
        chk("busy",         k, 64'(busy_o[k]),  64'(ph[k] != 0));
        chk("done",         k, 64'(done_o[k]),  64'((ph[k] == 2) ? (N'(1) << gw[k]) : N'(0)));
        chk("grant_id",     k, 64'(gid_o[k]),   64'(gw[k]));
        chk("mem_address",  k, 64'(maddr_o[k]), 64'(t_addr[k]));
        chk("mem_wr_en",    k, 64'(mwr_o[k]),   64'(t_wr[k]));
        chk("mem_data_out", k, mdo_o[k],        t_data[k]);
        chk("data_out",     k, dout_o[k],       m_dout[k]);
      end
    end
  end

  // ---------------- memory responder ----------------
  bit auto_mem[NI] = '{1'b0, 1'b0};
  int lat_cnt [NI] = '{2, 2};

  initial begin
    forever begin
      @(posedge clk); #1;
      for (int k = 0; k < NI; k++) begin
        if (auto_mem[k]) begin
          mvalid_s[k] = 1'b0;
          if (mreq_o[k]) begin
            if (lat_cnt[k] == 0) begin
              mvalid_s[k] = 1'b1;
              fmem_s[k]   = {$urandom, $urandom};
              lat_cnt[k]  = $urandom_range(4, 0);
            end else begin
              lat_cnt[k]--;
            end
          end
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic set_port(input int k, input int p, input bit r, input bit w,
                          input logic [AW-1:0] a, input logic [BW-1:0] d);
    req_s[k][p]             = r;
    wr_s[k][p]              = w;
    addr_s[k][p*AW +: AW]   = a;
    din_s[k][p*BW +: BW]    = d;
  endtask

  task automatic wait_mreq(input int k, input int lim);
    int n;
    n = 0;
    while (!mreq_o[k] && n < lim) begin
      tick();
      n++;
    end
    n_checks++;
    if (!mreq_o[k]) begin
      n_errors++;
      $display("FAIL wait_mem_req[inst%0d]: mem_req still 0 after %0d cycles, want 1", k, lim);
    end
  endtask

  task automatic wait_idle(input int k, input int lim);
    int n;
    n = 0;
    while (busy_o[k] && n < lim) begin
      tick();
      n++;
    end
    n_checks++;
    if (busy_o[k]) begin
      n_errors++;
      $display("FAIL wait_idle[inst%0d]: busy still 1 after %0d cycles, want 0", k, lim);
    end
  endtask

  int exp_rr[6] = '{0, 1, 2, 3, 0, 1};
  int exp_fp[6] = '{0, 2, 0, 2, 0, 2};

  initial begin
    int hb0, hb1, n;
    rst = 1'b1;
    for (int k = 0; k < NI; k++) begin
      req_s[k] = '0; wr_s[k] = '0; addr_s[k] = '0; din_s[k] = '0;
      fmem_s[k] = '0; mvalid_s[k] = 1'b0;
    end
    tick();
    cmp_en = 1'b1;
    tick();
    tick();
    rst = 1'b0;

    // Reset state, literal.
    chk("rst_mem_req",  0, 64'(mreq_o[0]), 64'd0);
    chk("rst_busy",     0, 64'(busy_o[0]), 64'd0);
    chk("rst_grant_id", 0, 64'(gid_o[0]),  64'd0);
    chk("rst_done",     0, 64'(done_o[0]), 64'd0);
    chk("rst_data_out", 0, dout_o[0],      64'd0);

    // Single read from port 1, memory answers 5 cycles after mem_req.
    set_port(0, 1, 1'b1, 1'b0, 32'h1000, 64'h0);
    wait_mreq(0, 10);
    chk("rd_mem_address", 0, 64'(maddr_o[0]), 64'h1000);
    chk("rd_mem_wr_en",   0, 64'(mwr_o[0]),   64'd0);
    repeat (4) tick();
    mvalid_s[0] = 1'b1;
    fmem_s[0]   = 64'hABAB_ABAB_ABAB_ABAB;
    tick();
    mvalid_s[0] = 1'b0;
    set_port(0, 1, 1'b0, 1'b0, 32'h1000, 64'h0);
    chk("rd_done",     0, 64'(done_o[0]), 64'b0010);
    chk("rd_data_out", 0, dout_o[0],      64'hABAB_ABAB_ABAB_ABAB);
    tick();
    chk("rd_done_clr", 0, 64'(done_o[0]), 64'd0);
    chk("rd_busy_clr", 0, 64'(busy_o[0]), 64'd0);

    // Spurious valid while idle.
    tick();
    mvalid_s[0] = 1'b1;
    fmem_s[0]   = 64'h1234_5678_9ABC_DEF0;
    tick();
    mvalid_s[0] = 1'b0;
    tick();
    chk("spur_done",     0, 64'(done_o[0]), 64'd0);
    chk("spur_data_out", 0, dout_o[0],      64'hABAB_ABAB_ABAB_ABAB);

    // Write from port 0 on the fixed-priority instance; operands are
    // changed mid-transaction and must not leak through.
    set_port(1, 0, 1'b1, 1'b1, 32'h2040, 64'h5555_5555_5555_5555);
    wait_mreq(1, 10);
    chk("wr_mem_address", 1, 64'(maddr_o[1]), 64'h2040);
    set_port(1, 0, 1'b1, 1'b0, 32'hDEAD, 64'h0F0F_0F0F_0F0F_0F0F);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("wr_mem_wr_en",    1, 64'(mwr_o[1]),  64'd1);
      chk("wr_mem_data_out", 1, mdo_o[1],       64'h5555_5555_5555_5555);
      chk("wr_mem_req",      1, 64'(mreq_o[1]), 64'd1);
    end
    mvalid_s[1] = 1'b1;
    fmem_s[1]   = 64'h0;
    tick();
    mvalid_s[1] = 1'b0;
    set_port(1, 0, 1'b0, 1'b0, 32'h0, 64'h0);
    chk("wr_done", 1, 64'(done_o[1]), 64'b0001);
    tick();
    tick();

    // Grant order: all four ports on round-robin, ports 0 and 2 on fixed.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    hb0 = gcnt[0];
    hb1 = gcnt[1];
    for (int p = 0; p < N; p++) set_port(0, p, 1'b1, 1'b0, $urandom, 64'h0);
    set_port(1, 0, 1'b1, 1'b0, 32'h100, 64'h0);
    set_port(1, 2, 1'b1, 1'b0, 32'h300, 64'h0);
    auto_mem[0] = 1'b1;
    auto_mem[1] = 1'b1;
    n = 0;
    while ((gcnt[0] < hb0 + 6 || gcnt[1] < hb1 + 6) && n < 300) begin
      tick();
      n++;
    end
    n_checks++;
    if (gcnt[0] < hb0 + 6 || gcnt[1] < hb1 + 6) begin
      n_errors++;
      $display("FAIL grant_count: got %0d/%0d grants, want 6/6", gcnt[0] - hb0, gcnt[1] - hb1);
    end
    for (int i = 0; i < 6; i++) begin
      chk("rr_order", 0, 64'(ghist[0][hb0 + i]), 64'(exp_rr[i]));
      chk("fp_order", 1, 64'(ghist[1][hb1 + i]), 64'(exp_fp[i]));
    end
    for (int k = 0; k < NI; k++) req_s[k] = '0;
    wait_idle(0, 40);
    wait_idle(1, 40);
    tick();
    tick();
    auto_mem[0] = 1'b0;
    auto_mem[1] = 1'b0;
    tick();
    mvalid_s[0] = 1'b0;
    mvalid_s[1] = 1'b0;

    // Reset in the middle of a transaction, then a late valid.
    set_port(0, 2, 1'b1, 1'b0, 32'h3000, 64'h0);
    wait_mreq(0, 10);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    set_port(0, 2, 1'b0, 1'b0, 32'h3000, 64'h0);
    chk("mrst_mem_req", 0, 64'(mreq_o[0]), 64'd0);
    chk("mrst_busy",    0, 64'(busy_o[0]), 64'd0);
    tick();
    mvalid_s[0] = 1'b1;
    fmem_s[0]   = 64'hFFFF_0000_FFFF_0000;
    tick();
    mvalid_s[0] = 1'b0;
    chk("mrst_done", 0, 64'(done_o[0]), 64'd0);
    set_port(0, 0, 1'b1, 1'b0, 32'h4000, 64'h0);
    set_port(0, 2, 1'b1, 1'b0, 32'h3000, 64'h0);
    wait_mreq(0, 10);
    chk("mrst_next_grant", 0, 64'(gid_o[0]), 64'd0);
    req_s[0] = '0;
    auto_mem[0] = 1'b1;
    auto_mem[1] = 1'b1;
    wait_idle(0, 20);

    // Randomized traffic against both instances.
    for (int c = 0; c < 1500; c++) begin
      tick();
      for (int k = 0; k < NI; k++) begin
        for (int p = 0; p < N; p++) begin
          if (req_s[k][p]) begin
            if (done_o[k][p]) begin
              if ($urandom_range(1, 0) == 0)
                set_port(k, p, 1'b0, 1'b0, 32'h0, 64'h0);
              else
                set_port(k, p, 1'b1, 1'($urandom), $urandom, {$urandom, $urandom});
            end
          end else if ($urandom_range(3, 0) == 0) begin
            set_port(k, p, 1'b1, 1'($urandom), $urandom, {$urandom, $urandom});
          end
        end
      end
    end
    for (int k = 0; k < NI; k++) req_s[k] = '0;
    wait_idle(0, 40);
    wait_idle(1, 40);
    tick();
    tick();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
